// File: rtl/psola_playback_pkg.sv
// Shared types and default sizing for the PSOLA playback output stage.
package psola_playback_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } playback_state_t;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned DEF_MAX_EXTENDED = 2200;
    localparam int unsigned DEF_DEPTH        = 8192;
    localparam int unsigned DEF_OUT_WIDTH    = 16;
    localparam int unsigned DEF_SHIFT        = 0;

endpackage

// File: rtl/psola_playback_sat_shift.sv
// Arithmetic right shift followed by a signed clamp to the DAC width; purely combinational.
module psola_playback_sat_shift #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] sat_c
);

    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-(2 ** (OUT_W - 1)));

    logic signed [IN_W-1:0] shifted;

    assign shifted = din >>> SHIFT;

    always_comb begin
        sat_c = OUT_W'(shifted);
        if (shifted > SAT_MAX) begin
            sat_c = OUT_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            sat_c = OUT_W'(SAT_MIN);
        end
    end

endmodule

// File: rtl/psola_playback.sv
// Ring buffer between burst-written PSOLA windows and the audio-rate DAC feed.
module psola_playback
    import psola_playback_pkg::*;
#(
    parameter int unsigned MAX_EXTENDED = DEF_MAX_EXTENDED,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int unsigned SHIFT        = DEF_SHIFT,
    localparam int unsigned ADDR_W      = $clog2(MAX_EXTENDED),
    localparam int unsigned PTR_W       = $clog2(DEPTH),
    localparam int unsigned CNT_W       = PTR_W + 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic signed [DATA_W-1:0]    val_in,
    input  logic [ADDR_W-1:0]           addr_in,
    input  logic                        valid_in,
    input  logic                        window_done_in,
    input  logic                        sample_tick_in,
    output logic signed [OUT_WIDTH-1:0] sample_out,
    output logic                        sample_valid_out,
    output logic                        underrun_out,
    output logic                        overflow_out,
    output logic [CNT_W-1:0]            fill_out
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    playback_state_t state, state_nxt;

    logic [PTR_W-1:0]  wr_base, rd_ptr, wr_addr;
    logic [CNT_W-1:0]  occupancy;
    logic [LEN_W-1:0]  win_len, win_len_upd, len_cand;
    logic              done_q, overflow_q;
    logic              done_rise, has_space, addr_ok;
    logic              filling, wr_en, commit, drop_set, rd_en, under;

    logic [DATA_W-1:0] ring [DEPTH];
    logic [DATA_W-1:0] ram_q, ram_dout;
    logic [1:0]        vld_pipe, und_pipe;
    logic signed [OUT_WIDTH-1:0] sat_c;

    assign done_rise = window_done_in & ~done_q;
    assign has_space = (CNT_W'(DEPTH) - occupancy) >= CNT_W'(MAX_EXTENDED);
    assign addr_ok   = LEN_W'(addr_in) < LEN_W'(MAX_EXTENDED);
    assign len_cand  = LEN_W'(addr_in) + LEN_W'(1);
    assign wr_addr   = wr_base + PTR_W'(addr_in);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= W_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A done rise always closes the window, whether it was being filled or dropped.
    always_comb begin
        state_nxt = state;
        unique case (state)
            W_IDLE:  if (valid_in) state_nxt = has_space ? W_FILL : W_DROP;
            W_FILL:  state_nxt = W_FILL;
            W_DROP:  state_nxt = W_DROP;
            default: state_nxt = W_IDLE;
        endcase
        if (done_rise) begin
            state_nxt = W_IDLE;
        end
    end

    // The first accepted word of a window is written in the same cycle it leaves W_IDLE.
    always_comb begin
        filling     = (state == W_FILL) || (state == W_IDLE && valid_in && has_space);
        wr_en       = filling && valid_in && addr_ok;
        win_len_upd = (wr_en && (len_cand > win_len)) ? len_cand : win_len;
        commit      = filling && done_rise;
        drop_set    = (state == W_IDLE) && valid_in && !has_space;
        rd_en       = sample_tick_in && (occupancy != '0);
        under       = sample_tick_in && (occupancy == '0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_base    <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            win_len    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            vld_pipe   <= '0;
            und_pipe   <= '0;
        end else begin
            done_q     <= window_done_in;
            win_len    <= commit ? LEN_W'(0) : win_len_upd;
            overflow_q <= overflow_q | drop_set;
            if (commit) begin
                wr_base <= wr_base + PTR_W'(win_len_upd);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occupancy <= occupancy
                       + (commit ? CNT_W'(win_len_upd) : CNT_W'(0))
                       - (rd_en ? CNT_W'(1) : CNT_W'(0));
            vld_pipe <= {vld_pipe[0], sample_tick_in};
            und_pipe <= {und_pipe[0], under};
        end
    end

    // Read-first dual-port storage with an extra output register on the read port.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            ring[wr_addr] <= val_in;
        end
        if (rd_en) begin
            ram_q <= ring[rd_ptr];
        end
        ram_dout <= ram_q;
    end

    psola_playback_sat_shift #(
        .IN_W  (DATA_W),
        .OUT_W (OUT_WIDTH),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .din   (ram_dout),
        .sat_c (sat_c)
    );

    assign sample_out       = (vld_pipe[1] && !und_pipe[1]) ? sat_c : '0;
    assign sample_valid_out = vld_pipe[1];
    assign underrun_out     = und_pipe[1];
    assign overflow_out     = overflow_q;
    assign fill_out         = occupancy;

endmodule
